// File: rtl/instr_fetch_split_if.sv
// instr_fetch_split_if: control-strobe, PC and program-memory bus bundle for the fetch unit
interface instr_fetch_split_if #(parameter int ADDR_W = 8);
  logic CS_Ins_load, CS_PC_load, CS_PC_inc, pc_wr_en;
  logic [ADDR_W-1:0] pc_wr_data, mem_addr, pc;
  logic mem_rd_req, mem_rd_valid, ins_valid, busy;
  logic [15:0] mem_rdata, imm16;
  logic [3:0] CS_opcode, rd_sel, rs_sel, imm4;
  modport master (
    input CS_Ins_load, CS_PC_load, CS_PC_inc, pc_wr_en, pc_wr_data, mem_rd_valid, mem_rdata,
    output mem_addr, mem_rd_req, CS_opcode, rd_sel, rs_sel, imm4, imm16, ins_valid, busy, pc
  );
  modport slave (
    output CS_Ins_load, CS_PC_load, CS_PC_inc, pc_wr_en, pc_wr_data, mem_rd_valid, mem_rdata,
    input mem_addr, mem_rd_req, CS_opcode, rd_sel, rs_sel, imm4, imm16, ins_valid, busy, pc
  );
endinterface

// File: rtl/instr_fetch_split.sv
// instr_fetch_split: PC owner that fetches 1/2-word instructions and splits them into fields
module instr_fetch_split #(
  parameter int ADDR_W = 8,
  parameter logic [3:0] TWO_WORD_OPC = 4'b0001
) (
  input logic clk,
  input logic rst,
  instr_fetch_split_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, READY} state_t;
  state_t state;
  logic [15:0] ir;
  logic [ADDR_W-1:0] npc;
  logic idle_or_ready, start, two_ir;
  assign bus.CS_opcode = ir[15:12];
  assign bus.rd_sel = ir[11:8];
  assign bus.rs_sel = ir[7:4];
  assign bus.imm4 = ir[3:0];
  // npc is the PC after this cycle's jump/increment, so a same-cycle start fetches from it
  always_comb begin
    idle_or_ready = state == IDLE || state == READY;
    start = bus.CS_Ins_load && bus.CS_PC_load && idle_or_ready;
    two_ir = ir[15:12] == TWO_WORD_OPC;
    npc = bus.pc_wr_en ? bus.pc_wr_data :
          !(bus.CS_PC_inc && idle_or_ready) ? bus.pc :
          bus.pc + ((state == READY && two_ir) ? ADDR_W'(2) : ADDR_W'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.pc <= '0;
      bus.mem_addr <= '0;
      ir <= '0;
      bus.imm16 <= '0;
      bus.mem_rd_req <= 1'b0;
      bus.ins_valid <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.pc <= npc;
      case (state)
        FETCH1: if (bus.mem_rd_valid) begin
          ir <= bus.mem_rdata;
          if (bus.mem_rdata[15:12] == TWO_WORD_OPC) begin
            state <= FETCH2;
            bus.mem_addr <= bus.mem_addr + 1'b1;
          end else begin
            state <= READY;
            bus.mem_rd_req <= 1'b0;
            bus.busy <= 1'b0;
            bus.ins_valid <= 1'b1;
          end
        end
        FETCH2: if (bus.mem_rd_valid) begin
          bus.imm16 <= bus.mem_rdata;
          state <= READY;
          bus.mem_rd_req <= 1'b0;
          bus.busy <= 1'b0;
          bus.ins_valid <= 1'b1;
        end
        default: if (start) begin
          state <= FETCH1;
          bus.mem_addr <= npc;
          bus.mem_rd_req <= 1'b1;
          bus.busy <= 1'b1;
          bus.ins_valid <= 1'b0;
          bus.imm16 <= '0;
        end else if (state == READY && (bus.pc_wr_en || bus.CS_PC_inc)) begin
          state <= IDLE;
          bus.ins_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_split.sv
// tb_instr_fetch_split: directed plan cases plus random traffic against a transaction-level model
module tb_instr_fetch_split;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  instr_fetch_split_if #(.ADDR_W(8)) bus();
  instr_fetch_split #(.ADDR_W(8), .TWO_WORD_OPC(4'b0001)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] mem [256];
  int wait_n = 0, cnt = 0, vectors = 0, errors = 0;
  bit late = 0, armed = 0;
  int m_pc, m_addr;
  bit m_busy, m_second, m_valid, acc, st;
  logic [15:0] m_ir, m_imm;

  function automatic bit two(input logic [15:0] w);
    return w[15:12] == 4'h1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory responder: valid after wait_n cycles of request; late forces a stray response
  always @(negedge clk) begin
    if (bus.mem_rd_valid) cnt = 0;
    if (late) begin
      bus.mem_rd_valid = 1;
      bus.mem_rdata = 16'h1F00;
    end else if (bus.mem_rd_req === 1'b1 && cnt >= wait_n) begin
      bus.mem_rd_valid = 1;
      bus.mem_rdata = mem[bus.mem_addr];
    end else begin
      bus.mem_rd_valid = 0;
      bus.mem_rdata = 16'($urandom);
      cnt = (bus.mem_rd_req === 1'b1) ? cnt + 1 : 0;
    end
  end

  // model: pc arithmetic plus the address list of the current fetch, checked every cycle
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_addr = 0; m_busy = 0; m_second = 0; m_valid = 0; m_ir = 0; m_imm = 0; armed = 1;
    end else if (armed) begin
      acc = m_busy && bus.mem_rd_valid;
      st = bus.CS_Ins_load && bus.CS_PC_load && !m_busy;
      if (bus.pc_wr_en) m_pc = bus.pc_wr_data;
      else if (bus.CS_PC_inc && !m_busy) m_pc = (m_pc + ((m_valid && two(m_ir)) ? 2 : 1)) % 256;
      if (!m_busy && (bus.pc_wr_en || bus.CS_PC_inc)) m_valid = 0;
      if (st) begin
        m_busy = 1; m_second = 0; m_addr = m_pc; m_valid = 0; m_imm = 0;
      end else if (acc && !m_second) begin
        m_ir = mem[m_addr];
        if (two(m_ir)) begin
          m_second = 1;
          m_addr = (m_addr + 1) % 256;
        end else begin
          m_busy = 0; m_valid = 1;
        end
      end else if (acc) begin
        m_imm = mem[m_addr]; m_busy = 0; m_valid = 1;
      end
    end
    #1;
    if (armed) begin
      chk("pc", bus.pc, m_pc);
      chk("busy", bus.busy, m_busy);
      chk("req", bus.mem_rd_req, m_busy);
      chk("ins_valid", bus.ins_valid, m_valid);
      chk("opcode", bus.CS_opcode, m_ir[15:12]);
      chk("rd_sel", bus.rd_sel, m_ir[11:8]);
      chk("rs_sel", bus.rs_sel, m_ir[7:4]);
      chk("imm4", bus.imm4, m_ir[3:0]);
      chk("imm16", bus.imm16, m_imm);
      if (m_busy) chk("mem_addr", bus.mem_addr, m_addr);
    end
  end

  task automatic drive(input bit ld, input bit inc, input bit wr, input logic [7:0] wd);
    @(negedge clk);
    bus.CS_Ins_load = ld;
    bus.CS_PC_load = ld;
    bus.CS_PC_inc = inc;
    bus.pc_wr_en = wr;
    bus.pc_wr_data = wd;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.ins_valid !== 1'b1 && n < 64) begin
      drive(0, 0, 0, 0);
      n++;
    end
    if (bus.ins_valid !== 1'b1) chk("ready_timeout", bus.ins_valid, 1);
  endtask

  initial begin
    bus.CS_Ins_load = 0; bus.CS_PC_load = 0; bus.CS_PC_inc = 0;
    bus.pc_wr_en = 0; bus.pc_wr_data = 0; bus.mem_rd_valid = 0; bus.mem_rdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if (i % 3 == 0) mem[i][15:12] = 4'h1;
    end
    mem[8'h00] = 16'h2345;
    mem[8'h10] = 16'h1A00; mem[8'h11] = 16'hBEEF;
    mem[8'hFF] = 16'h1100;
    mem[8'h20] = 16'h1300; mem[8'h21] = 16'h7777;
    mem[8'h40] = 16'h5678; mem[8'h41] = 16'h0123;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_pc", bus.pc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.ins_valid, 0);
    // zero-wait single-word fetch
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("tp1_req", bus.mem_rd_req, 1);
    chk("tp1_addr", bus.mem_addr, 8'h00);
    drive(0, 0, 0, 0);
    chk("tp1_valid", bus.ins_valid, 1);
    chk("tp1_opc", bus.CS_opcode, 2);
    chk("tp1_rd", bus.rd_sel, 3);
    chk("tp1_rs", bus.rs_sel, 4);
    chk("tp1_imm4", bus.imm4, 5);
    chk("tp1_imm16", bus.imm16, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("tp1_pc", bus.pc, 8'h01);
    // two-word fetch with three wait cycles per word: ready in cycle 9
    wait_n = 3;
    drive(0, 0, 1, 8'h10);
    drive(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, 0);
      if (i == 3) chk("tp2_addr1", bus.mem_addr, 8'h10);
      if (i == 7) chk("tp2_addr2", bus.mem_addr, 8'h11);
    end
    chk("tp2_early", bus.ins_valid, 0);
    drive(0, 0, 0, 0);
    chk("tp2_valid", bus.ins_valid, 1);
    chk("tp2_imm16", bus.imm16, 16'hBEEF);
    chk("tp2_rd", bus.rd_sel, 4'hA);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("tp2_pc", bus.pc, 8'h12);
    chk("tp2_model_pc", m_pc, 8'h12);
    // second word address wraps
    wait_n = 0;
    drive(0, 0, 1, 8'hFF);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("tp3_addr1", bus.mem_addr, 8'hFF);
    drive(0, 0, 0, 0);
    chk("tp3_addr2", bus.mem_addr, 8'h00);
    drive(0, 0, 0, 0);
    chk("tp3_imm16", bus.imm16, 16'h2345);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("tp3_pc", bus.pc, 8'h01);
    mem[8'h00] = 16'h0042;
    // reset during the FETCH2 wait, stray response afterwards
    wait_n = 2;
    drive(0, 0, 1, 8'h20);
    drive(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) drive(0, 0, 0, 0);
    chk("tp4_addr2", bus.mem_addr, 8'h21);
    rst = 1; late = 1;
    @(negedge clk);
    rst = 0;
    chk("tp4_pc", bus.pc, 0);
    chk("tp4_req", bus.mem_rd_req, 0);
    chk("tp4_busy", bus.busy, 0);
    chk("tp4_ir", bus.CS_opcode, 0);
    @(negedge clk);
    late = 0;
    chk("tp4_late_valid", bus.ins_valid, 0);
    chk("tp4_late_ir", bus.CS_opcode, 0);
    chk("tp4_late_busy", bus.busy, 0);
    // jump and repeated start while busy
    wait_n = 1;
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 8'h40);
    wait_ready();
    chk("tp5_pc", bus.pc, 8'h40);
    chk("tp5_imm4", bus.imm4, 2);
    chk("tp5_opc", bus.CS_opcode, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("tp5_addr", bus.mem_addr, 8'h40);
    drive(0, 1, 0, 0);
    wait_ready();
    chk("tp6_pc", bus.pc, 8'h40);
    chk("tp6_opc", bus.CS_opcode, 5);
    // increment and start together in READY
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("tp7_pc", bus.pc, 8'h41);
    chk("tp7_addr", bus.mem_addr, 8'h41);
    wait_ready();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 299) == 0;
      bus.CS_Ins_load = $urandom_range(0, 3) == 0;
      bus.CS_PC_load = bus.CS_Ins_load ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      bus.CS_PC_inc = $urandom_range(0, 4) == 0;
      bus.pc_wr_en = $urandom_range(0, 15) == 0;
      bus.pc_wr_data = 8'($urandom);
      wait_n = $urandom_range(0, 2);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
